// File: rtl/phase_duration_timer.sv
// phase_duration_timer
//   Phase countdown for the traffic controller. A load request computes the
//   duration of a green or orange phase (green scales with lane congestion),
//   then counts it down at a prescaled tick rate. done pulses for one cycle
//   when the count reaches zero.
//   Optional feature macro: TIMER_PAUSE_EN adds a 'pause' input that freezes
//   the countdown while in RUN. Without it the countdown is uninterrupted.
module phase_duration_timer #(
    parameter int CW          = 5,
    parameter int TICK_DIV    = 4,
    parameter int GREEN_BASE  = 8,
    parameter int GREEN_STEP  = 4,
    parameter int ORANGE_TIME = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_counter,
    input  logic          load_kind,
    input  logic [1:0]    load_level,
`ifdef TIMER_PAUSE_EN
    input  logic          pause,
`endif
    output logic [CW-1:0] counter_value,
    output logic          done,
    output logic          busy
);

    // Prescaler needs at least one bit even when every cycle is a tick.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Duration arithmetic is done wide enough that base + 3*step cannot wrap.
    localparam int DW = CW + 3;
    localparam logic [DW-1:0] MAX_DUR  = DW'((1 << CW) - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_pre;
    logic          r_done;

    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [PW-1:0] w_pre_nx;
    logic          w_done_nx;

    logic [DW-1:0] w_green;
    logic [DW-1:0] w_raw_dur;
    logic [CW-1:0] w_dur;
    logic          w_adv;
    logic          w_tick;

    // Phase duration from kind and congestion level, saturated to the counter range.
    always_comb begin
        w_green   = DW'(GREEN_BASE) + (DW'(load_level) * DW'(GREEN_STEP));
        w_raw_dur = load_kind ? DW'(ORANGE_TIME) : w_green;
        w_dur     = (w_raw_dur > MAX_DUR) ? MAX_DUR[CW-1:0] : w_raw_dur[CW-1:0];
    end

    // Countdown advances only in RUN, and only while not paused.
    always_comb begin
`ifdef TIMER_PAUSE_EN
        w_adv  = (r_state == S_RUN) && !pause;
`else
        w_adv  = (r_state == S_RUN);
`endif
        w_tick = (r_pre == PRE_LAST);
    end

    // Next-state logic: a load always wins over a tick, including the terminal one.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pre_nx   = r_pre;
        w_done_nx  = 1'b0;
        if (load_counter) begin
            w_state_nx = S_RUN;
            w_cnt_nx   = w_dur;
            w_pre_nx   = '0;
        end else if (w_adv) begin
            if (w_tick) begin
                w_pre_nx = '0;
                if (r_cnt <= CW'(1)) begin
                    // Terminal tick; a zero count in RUN is unreachable but is
                    // handled by dropping back to IDLE without a done pulse.
                    w_cnt_nx   = '0;
                    w_done_nx  = (r_cnt == CW'(1));
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end else begin
                w_pre_nx = r_pre + PW'(1);
            end
        end
    end

    // State, counter, prescaler and done registers; reset aborts any countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pre   <= w_pre_nx;
            r_done  <= w_done_nx;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        counter_value = r_cnt;
        done          = r_done;
        busy          = (r_state == S_RUN);
    end

endmodule

// File: tb/tb_phase_duration_timer.sv
// Directed bench for phase_duration_timer. A second instance with
// GREEN_BASE=24 shares the stimulus to exercise duration saturation.
module tb_phase_duration_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_counter = 1'b0;
    logic       load_kind = 1'b0;
    logic [1:0] load_level = 2'd0;
`ifdef TIMER_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [4:0] cv, cv_s;
    logic       done, busy, done_s, busy_s;

    int n_tot = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    phase_duration_timer u_dut (
        .clk(clk), .rst_n(rst_n), .load_counter(load_counter),
        .load_kind(load_kind), .load_level(load_level),
`ifdef TIMER_PAUSE_EN
        .pause(pause),
`endif
        .counter_value(cv), .done(done), .busy(busy)
    );

    phase_duration_timer #(.GREEN_BASE(24)) u_sat (
        .clk(clk), .rst_n(rst_n), .load_counter(load_counter),
        .load_kind(load_kind), .load_level(load_level),
`ifdef TIMER_PAUSE_EN
        .pause(pause),
`endif
        .counter_value(cv_s), .done(done_s), .busy(busy_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic kind, input logic [1:0] lvl);
        load_counter = 1'b1;
        load_kind    = kind;
        load_level   = lvl;
        step();
        load_counter = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tot++;
        if (cv !== 5'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_state cv=%0d busy=%b done=%b want 0/0/0", cv, busy, done);
        else n_pass++;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_green();
        int cyc = 0;
        do_load(1'b0, 2'd2);
        n_tot++;
        if (cv !== 5'd16 || busy !== 1'b1 || done !== 1'b0)
            $display("FAIL green_load cv=%0d busy=%b done=%b want 16/1/0", cv, busy, done);
        else n_pass++;
        while (done !== 1'b1 && cyc < 200) begin
            step(); cyc++;
            if (cyc == 3) begin
                n_tot++;
                if (cv !== 5'd16) $display("FAIL green_hold cv=%0d want 16", cv);
                else n_pass++;
            end
            if (cyc == 4) begin
                n_tot++;
                if (cv !== 5'd15) $display("FAIL green_tick cv=%0d want 15", cv);
                else n_pass++;
            end
        end
        n_tot++;
        if (cyc != 64 || cv !== 5'd0 || busy !== 1'b0)
            $display("FAIL green_done cycles=%0d cv=%0d busy=%b want 64/0/0", cyc, cv, busy);
        else n_pass++;
        step();
        n_tot++;
        if (done !== 1'b0) $display("FAIL green_done_width done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_orange();
        int cyc = 0;
        do_load(1'b1, 2'd3);
        n_tot++;
        if (cv !== 5'd3 || busy !== 1'b1) $display("FAIL orange_load cv=%0d busy=%b want 3/1", cv, busy);
        else n_pass++;
        while (done !== 1'b1 && cyc < 100) begin
            step(); cyc++;
        end
        n_tot++;
        if (cyc != 12 || busy !== 1'b0) $display("FAIL orange_done cycles=%0d busy=%b want 12/0", cyc, busy);
        else n_pass++;
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 4; i++) begin
            step();
            n_tot++;
            if (cv !== 5'd0 || busy !== 1'b0 || done !== 1'b0)
                $display("FAIL idle_hold cv=%0d busy=%b done=%b want 0/0/0", cv, busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        do_load(1'b0, 2'd3);
        n_tot++;
        if (cv !== 5'd20 || cv_s !== 5'd31)
            $display("FAIL sat_lvl3 cv=%0d cv_s=%0d want 20/31", cv, cv_s);
        else n_pass++;
        do_load(1'b0, 2'd0);
        n_tot++;
        if (cv !== 5'd8 || cv_s !== 5'd24)
            $display("FAIL sat_lvl0 cv=%0d cv_s=%0d want 8/24", cv, cv_s);
        else n_pass++;
        do_load(1'b0, 2'd1);
        n_tot++;
        if (cv !== 5'd12 || cv_s !== 5'd28)
            $display("FAIL sat_lvl1 cv=%0d cv_s=%0d want 12/28", cv, cv_s);
        else n_pass++;
        do_load(1'b0, 2'd2);
        n_tot++;
        if (cv !== 5'd16 || cv_s !== 5'd31)
            $display("FAIL sat_lvl2 cv=%0d cv_s=%0d want 16/31", cv, cv_s);
        else n_pass++;
        do_load(1'b1, 2'd3);
        n_tot++;
        if (cv !== 5'd3 || cv_s !== 5'd3)
            $display("FAIL sat_orange cv=%0d cv_s=%0d want 3/3", cv, cv_s);
        else n_pass++;
    endtask

    task automatic test_reload();
        int cyc = 0;
        int dones = 0;
        do_load(1'b0, 2'd0);
        while (cv !== 5'd5 && cyc < 100) begin
            step(); cyc++;
            if (done === 1'b1) dones++;
        end
        n_tot++;
        if (cyc != 12) $display("FAIL reload_reach5 cycles=%0d want 12", cyc);
        else n_pass++;
        do_load(1'b0, 2'd0);
        n_tot++;
        if (cv !== 5'd8 || done !== 1'b0 || busy !== 1'b1 || dones != 0)
            $display("FAIL reload_restart cv=%0d done=%b busy=%b dones=%0d want 8/0/1/0", cv, done, busy, dones);
        else n_pass++;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            step(); cyc++;
        end
        n_tot++;
        if (cyc != 32) $display("FAIL reload_done cycles=%0d want 32", cyc);
        else n_pass++;
    endtask

    task automatic test_load_on_terminal();
        int cyc = 0;
        do_load(1'b1, 2'd0);
        while (cv !== 5'd1 && cyc < 100) begin
            step(); cyc++;
        end
        step(); step(); step();
        n_tot++;
        if (cv !== 5'd1 || done !== 1'b0) $display("FAIL term_pre cv=%0d done=%b want 1/0", cv, done);
        else n_pass++;
        do_load(1'b0, 2'd0);
        n_tot++;
        if (cv !== 5'd8 || done !== 1'b0 || busy !== 1'b1)
            $display("FAIL term_load_wins cv=%0d done=%b busy=%b want 8/0/1", cv, done, busy);
        else n_pass++;
        step();
        n_tot++;
        if (done !== 1'b0 || cv !== 5'd8) $display("FAIL term_no_done cv=%0d done=%b want 8/0", cv, done);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int cyc = 0;
        int dones = 0;
        do_load(1'b0, 2'd2);
        while (cv !== 5'd9 && cyc < 100) begin
            step(); cyc++;
        end
        n_tot++;
        if (cyc != 28) $display("FAIL rst_reach9 cycles=%0d want 28", cyc);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_tot++;
        if (cv !== 5'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_async cv=%0d busy=%b done=%b want 0/0/0", cv, busy, done);
        else n_pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done === 1'b1 || cv !== 5'd0) dones++;
        end
        n_tot++;
        if (dones != 0) $display("FAIL rst_no_done bad_cycles=%0d want 0", dones);
        else n_pass++;
    endtask

`ifdef TIMER_PAUSE_EN
    task automatic test_pause();
        int cyc = 0;
        int bad = 0;
        do_load(1'b0, 2'd0);
        while (cv !== 5'd6 && cyc < 100) begin
            step(); cyc++;
        end
        n_tot++;
        if (cyc != 8) $display("FAIL pause_reach6 cycles=%0d want 8", cyc);
        else n_pass++;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); cyc++;
            if (cv !== 5'd6 || busy !== 1'b1 || done !== 1'b0) bad++;
        end
        pause = 1'b0;
        n_tot++;
        if (bad != 0) $display("FAIL pause_freeze bad_cycles=%0d want 0", bad);
        else n_pass++;
        while (done !== 1'b1 && cyc < 200) begin
            step(); cyc++;
        end
        n_tot++;
        if (cyc != 42) $display("FAIL pause_done cycles=%0d want 42", cyc);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_green();
        test_orange();
        test_idle_hold();
        test_saturate();
        test_reload();
        test_load_on_terminal();
        test_reset_midrun();
`ifdef TIMER_PAUSE_EN
        test_pause();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
